// File: rtl/pwm_breath_ctrl.sv
// Breathing-profile sequencer for the 8-bit LED PWM: ramps duty up, holds, ramps down, holds,
// and owns the registered PWM comparator. Duty is only updated at PWM period boundaries.
module pwm_breath_ctrl #(
  parameter logic [7:0] STEP    = 8'd1,
  parameter logic [7:0] PRE_RST = 8'd15,
  parameter logic [7:0] HHI_RST = 8'd0,
  parameter logic [7:0] HLO_RST = 8'd0
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] duty,
  output logic       pwm_out,
  output logic [2:0] state,
  output logic       cycle_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UP      = 3'd1,
    S_HOLD_HI = 3'd2,
    S_DOWN    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_t;

  state_t     cur, nxt;
  logic [7:0] pre_reg, hhi_reg, hlo_reg;
  logic       oneshot;
  logic [7:0] pwm_cnt, pre_cnt, hold_cnt, duty_work;
  logic [7:0] dw_nxt, hold_nxt;
  logic       done_nxt, pre_clr;
  logic       ctrl_wr, start, stop, bnd, tick;

  // EN acts on the write itself, so a finished one-shot stays idle until EN is written again
  assign ctrl_wr = cfg_we && (cfg_addr == 2'd3);
  assign start   = ctrl_wr && cfg_wdata[0];
  assign stop    = ctrl_wr && !cfg_wdata[0];
  assign bnd     = (pwm_cnt == 8'd255);
  assign tick    = bnd && (pre_cnt >= pre_reg);
  assign state   = cur;

  always_comb begin
    nxt      = cur;
    dw_nxt   = duty_work;
    hold_nxt = hold_cnt;
    done_nxt = 1'b0;
    pre_clr  = 1'b0;
    case (cur)
      S_IDLE: begin
        dw_nxt = '0;
        if (start) begin
          nxt      = S_UP;
          hold_nxt = '0;
          pre_clr  = 1'b1;
        end
      end
      S_UP: if (tick) begin
        if (duty_work > (8'd255 - STEP)) begin
          dw_nxt   = '1;
          hold_nxt = '0;
          nxt      = S_HOLD_HI;
        end else begin
          dw_nxt = duty_work + STEP;
        end
      end
      S_HOLD_HI: if (tick) begin
        if (hold_cnt == hhi_reg) nxt = S_DOWN;
        else hold_nxt = hold_cnt + 8'd1;
      end
      S_DOWN: if (tick) begin
        if (duty_work < STEP) begin
          dw_nxt   = '0;
          hold_nxt = '0;
          nxt      = S_HOLD_LO;
        end else begin
          dw_nxt = duty_work - STEP;
        end
      end
      S_HOLD_LO: if (tick) begin
        if (hold_cnt == hlo_reg) begin
          done_nxt = 1'b1;
          hold_nxt = '0;
          nxt      = oneshot ? S_IDLE : S_UP;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: nxt = S_IDLE;
    endcase
    // An EN=0 write overrides whatever the step logic decided this clock
    if (cur != S_IDLE && stop) begin
      nxt      = S_IDLE;
      dw_nxt   = '0;
      hold_nxt = '0;
      pre_clr  = 1'b1;
      done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      cur        <= S_IDLE;
      pre_reg    <= PRE_RST;
      hhi_reg    <= HHI_RST;
      hlo_reg    <= HLO_RST;
      oneshot    <= 1'b0;
      pwm_cnt    <= '0;
      pre_cnt    <= '0;
      hold_cnt   <= '0;
      duty_work  <= '0;
      duty       <= '0;
      pwm_out    <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      cur        <= nxt;
      duty_work  <= dw_nxt;
      hold_cnt   <= hold_nxt;
      cycle_done <= done_nxt;
      pwm_cnt    <= pwm_cnt + 8'd1;
      pwm_out    <= (pwm_cnt < duty);
      if (bnd) duty <= duty_work;
      if (pre_clr) pre_cnt <= '0;
      else if (bnd) pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: pre_reg <= cfg_wdata;
          2'd1: hhi_reg <= cfg_wdata;
          2'd2: hlo_reg <= cfg_wdata;
          2'd3: oneshot <= cfg_wdata[1];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Directed bench for pwm_breath_ctrl built with STEP=100 so a whole breathing cycle fits in a
// short run; edge numbers are counted from reset release (pwm_cnt == edges mod 256).
module tb_pwm_breath_ctrl;
  logic       clk50 = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] duty;
  logic       pwm_out;
  logic [2:0] state;
  logic       cycle_done;

  int total = 0;
  int bad = 0;
  int edges = 0;
  int highs = 0;
  int last_hi = 0;
  int done_cnt = 0;

  typedef struct {
    int edge_n;
    int duty;
    int state;
    int done;
    int hi;
  } vec_t;
  vec_t tbl[$];

  pwm_breath_ctrl #(.STEP(8'd100), .PRE_RST(8'd15), .HHI_RST(8'd0), .HLO_RST(8'd0)) dut (
    .clk50(clk50), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .duty(duty), .pwm_out(pwm_out), .state(state), .cycle_done(cycle_done)
  );

  always #5 clk50 = ~clk50;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edges, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk50);
    #1;
    edges++;
    highs += int'(pwm_out);
    done_cnt += int'(cycle_done);
    if (edges % 256 == 0) begin
      last_hi = highs;
      highs = 0;
    end
  endtask

  task automatic run_to(input int t);
    while (edges < t) cycle();
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk50);
    #1;
    rst = 1'b0;
    edges = 0;
    highs = 0;
    done_cnt = 0;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_duty", int'(duty), 0);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_state", int'(state), 0);
    check("rst_done", int'(cycle_done), 0);

    // continuous breathing, PRE=0, holds 0
    tbl.push_back('{256,  0,   1, 0, -1});
    tbl.push_back('{512,  100, 1, 0, -1});
    tbl.push_back('{767,  100, 1, 0, -1});
    tbl.push_back('{768,  200, 2, 0, -1});
    tbl.push_back('{1024, 255, 3, 0, -1});
    tbl.push_back('{1280, 255, 3, 0, 255});
    tbl.push_back('{1536, 155, 3, 0, 255});
    tbl.push_back('{1792, 55,  4, 0, 155});
    tbl.push_back('{2047, 55,  4, 0, -1});
    tbl.push_back('{2048, 0,   1, 1, -1});
    tbl.push_back('{2049, 0,   1, 0, -1});
    tbl.push_back('{2304, 0,   1, 0, 0});
    tbl.push_back('{2560, 100, 1, 0, -1});

    do_reset();
    cfg_write(2'd0, 8'd0);
    cfg_write(2'd3, 8'h01);
    check("start_state", int'(state), 1);
    for (int i = 0; i < tbl.size(); i++) begin
      run_to(tbl[i].edge_n);
      check("tbl_duty", int'(duty), tbl[i].duty);
      check("tbl_state", int'(state), tbl[i].state);
      check("tbl_done", int'(cycle_done), tbl[i].done);
      if (tbl[i].hi >= 0) check("tbl_highs", last_hi, tbl[i].hi);
    end

    // asynchronous reset mid-ramp
    run_to(2570);
    check("pre_rst_pwm", int'(pwm_out), 1);
    rst = 1'b1;
    #1;
    check("async_pwm", int'(pwm_out), 0);
    check("async_duty", int'(duty), 0);
    check("async_state", int'(state), 0);

    // one-shot: single cycle_done, then idle with zero output
    do_reset();
    cfg_write(2'd0, 8'd0);
    cfg_write(2'd3, 8'h03);
    run_to(2048);
    check("os_done", int'(cycle_done), 1);
    check("os_state", int'(state), 0);
    run_to(2600);
    check("os_pulses", done_cnt, 1);
    check("os_duty", int'(duty), 0);
    check("os_highs", last_hi, 0);
    check("os_state_end", int'(state), 0);

    // EN cleared mid-UP at duty=100
    do_reset();
    cfg_write(2'd0, 8'd0);
    cfg_write(2'd3, 8'h01);
    run_to(599);
    cfg_write(2'd3, 8'h00);
    check("stop_state", int'(state), 0);
    check("stop_duty_hold", int'(duty), 100);
    run_to(767);
    check("stop_duty_767", int'(duty), 100);
    run_to(768);
    check("stop_duty_bnd", int'(duty), 0);

    // PRE=3: duty changes every 1024 clocks; PRE lowered below pre_cnt ticks at next bnd
    cfg_write(2'd0, 8'd3);
    run_to(799);
    cfg_write(2'd3, 8'h01);
    check("pre3_start", int'(state), 1);
    run_to(2047);
    check("pre3_d2047", int'(duty), 0);
    run_to(2048);
    check("pre3_d2048", int'(duty), 100);
    run_to(3071);
    check("pre3_d3071", int'(duty), 100);
    run_to(3072);
    check("pre3_d3072", int'(duty), 200);
    run_to(3399);
    cfg_write(2'd0, 8'd1);
    run_to(3449);
    cfg_write(2'd3, 8'h01);
    run_to(3583);
    check("pre1_before", int'(state), 1);
    run_to(3584);
    check("pre1_tick", int'(state), 2);

    // HOLD_HI=1 lasts two steps
    run_to(3599);
    cfg_write(2'd1, 8'd1);
    run_to(4096);
    check("hhi_step1", int'(state), 2);
    run_to(4607);
    check("hhi_before", int'(state), 2);
    run_to(4608);
    check("hhi_exit", int'(state), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
